instr_prefetch_buffer: RTL

- Core-side fetch stage directly upstream of core_instruction_top.
- Drives the core instruction interface (instr_req/instr_addr, instr_gnt/instr_rvalid/instr_rdata) toward the instruction memory.
- Buffers returned words in a small FIFO and presents them, with their PC, to decode over a valid/ready handshake.
- Handles branch redirects by flushing buffered words and discarding responses still in flight.

---
 rtl/instr_prefetch_buffer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches to instruction memory, keeps returned
// words with their PC in a small FIFO and hands them to decode over valid/ready.
// Branch redirects flush the FIFO and drop responses that are still in flight.
// Optional feature macro PREFETCH_BYPASS_EN: a response arriving while the FIFO is empty is
// presented to decode combinationally in the same cycle.

module instr_prefetch_buffer #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] BOOT_ADDR       = 32'h3000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        fetch_en_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   output logic        fetch_valid_o,
   input  logic        fetch_ready_i,
   output logic [31:0] fetch_rdata_o,
   output logic [31:0] fetch_addr_o
);

   localparam int unsigned   AW      = $clog2(DEPTH);
   localparam int unsigned   TW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [AW+1:0] DepthW  = (AW+2)'(DEPTH);
   localparam logic [AW:0]   MaxOutW = (AW+1)'(MAX_OUTSTANDING);
   localparam logic [AW:0]   CntOne  = (AW+1)'(1);
   localparam logic [TW-1:0] TagLast = TW'(MAX_OUTSTANDING - 1);
   localparam logic [TW-1:0] TagOne  = TW'(1);
   localparam logic [31:0]   BootPc  = {BOOT_ADDR[31:2], 2'b00};

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StReq     = 2'd1;
   localparam logic [1:0] StWaitGnt = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic          redir_q, redir_d;
   logic [31:0]   redir_addr_q, redir_addr_d;
   logic [AW:0]   outst_q, outst_d;
   logic [AW:0]   discard_q, discard_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

   logic [31:0] data_mem [DEPTH];
   logic [31:0] addr_mem [DEPTH];
   logic [31:0] tag_mem  [MAX_OUTSTANDING];

   logic [31:0]   branch_pc;
   logic          unused_branch_lsb;
   logic          gnt_w, rsp_drop, rsp_keep, push, pop, slot_free_n;
   logic          fifo_empty, fifo_full;
   logic [AW:0]   fifo_count, count_d;
   logic [AW-1:0] rd_idx;
   logic [31:0]   rsp_pc;

   assign branch_pc         = {branch_addr_i[31:2], 2'b00};
   assign unused_branch_lsb = ^branch_addr_i[1:0];

   assign instr_req_o  = (state_q != StIdle);
   assign instr_addr_o = pc_q;
   assign gnt_w        = instr_req_o & instr_gnt_i;

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = ({1'b0, fifo_count} == DepthW);
   assign rd_idx     = rd_ptr_q[AW-1:0];

   // Responses consume their PC tag whether kept or dropped, so the tag queue stays aligned.
   assign rsp_drop = instr_rvalid_i & (discard_q != '0);
   assign rsp_keep = instr_rvalid_i & (discard_q == '0) & ~branch_i;
   assign rsp_pc   = tag_mem[tag_rd_q];

   // Decode-side view of the FIFO head (or of the live response when bypassing).
   always_comb begin
      fetch_valid_o = ~fifo_empty;
      fetch_rdata_o = fifo_empty ? '0 : data_mem[rd_idx];
      fetch_addr_o  = fifo_empty ? '0 : addr_mem[rd_idx];
      push          = rsp_keep;
`ifdef PREFETCH_BYPASS_EN
      if (fifo_empty && rsp_keep) begin
         fetch_valid_o = 1'b1;
         fetch_rdata_o = instr_rdata_i;
         fetch_addr_o  = rsp_pc;
         push          = ~fetch_ready_i;
      end
`endif
      pop = ~fifo_empty & fetch_ready_i;
   end

   // Next-state for PC, redirect, counters, pointers and FSM.
   always_comb begin
      pc_d         = pc_q;
      redir_d      = redir_q;
      redir_addr_d = redir_addr_q;
      tag_wr_d     = tag_wr_q;
      tag_rd_d     = tag_rd_q;
      outst_d      = outst_q;
      discard_d    = discard_q;
      wr_ptr_d     = wr_ptr_q + (push ? CntOne : '0);
      rd_ptr_d     = rd_ptr_q + (pop ? CntOne : '0);
      state_d      = state_q;

      if (gnt_w) begin
         // A redirect that arrived while this request was held takes effect once it is granted.
         pc_d     = redir_q ? redir_addr_q : pc_q + 32'd4;
         redir_d  = 1'b0;
         tag_wr_d = (tag_wr_q == TagLast) ? '0 : tag_wr_q + TagOne;
      end
      if (instr_rvalid_i) begin
         tag_rd_d = (tag_rd_q == TagLast) ? '0 : tag_rd_q + TagOne;
      end

      unique case ({gnt_w, instr_rvalid_i})
         2'b10:   outst_d = outst_q + CntOne;
         2'b01:   outst_d = outst_q - CntOne;
         default: outst_d = outst_q;
      endcase

      if (branch_i) begin
         // Everything still in flight after this cycle belongs to the old stream.
         discard_d = outst_d;
         wr_ptr_d  = wr_ptr_q;
         rd_ptr_d  = wr_ptr_q;
         if (instr_req_o && !instr_gnt_i) begin
            redir_d      = 1'b1;
            redir_addr_d = branch_pc;
         end else begin
            pc_d    = branch_pc;
            redir_d = 1'b0;
         end
      end else begin
         if (rsp_drop) discard_d = discard_d - CntOne;
         if (gnt_w && redir_q) discard_d = discard_d + CntOne;
      end

      count_d     = wr_ptr_d - rd_ptr_d;
      slot_free_n = (({1'b0, count_d} + {1'b0, outst_d}) < DepthW) && (outst_d < MaxOutW);

      case (state_q)
         StIdle: begin
            if (fetch_en_i && slot_free_n) state_d = StReq;
         end
         StReq, StWaitGnt: begin
            if (instr_gnt_i) state_d = (fetch_en_i && slot_free_n) ? StReq : StIdle;
            else             state_d = StWaitGnt;
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= StIdle;
         pc_q         <= BootPc;
         redir_q      <= 1'b0;
         redir_addr_q <= '0;
         outst_q      <= '0;
         discard_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         redir_q      <= redir_d;
         redir_addr_q <= redir_addr_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         tag_wr_q     <= tag_wr_d;
         tag_rd_q     <= tag_rd_d;
      end
   end

   // Storage arrays need no reset: pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (gnt_w) tag_mem[tag_wr_q] <= pc_q;
      if (push) begin
         data_mem[wr_ptr_q[AW-1:0]] <= instr_rdata_i;
         addr_mem[wr_ptr_q[AW-1:0]] <= rsp_pc;
      end
   end

   overflow_chk : assert property (@(posedge clk_i) disable iff (!reset_i)
      !(push && fifo_full && !pop))
      else $error("prefetch FIFO overflow");

endmodule
